vx_barrier_ctl: RTL and testbench

Consumer of the barrier field of the warp-control interface. It tracks warps arriving at local and global barriers and holds them stalled. It releases a local barrier when its warp count is reached. For a global barrier, it issues one request to the cluster barrier once all active local warps have arrived, and releases them when the matching response returns. It sits inside the warp scheduler and drives the per-warp barrier-stall mask.

---
 rtl/vx_barrier_ctl_if.sv | 43 ++++
 rtl/vx_barrier_ctl.sv | 152 +++++++++++++++
 tb/tb_vx_barrier_ctl.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/vx_barrier_ctl_if.sv
// Barrier-control bundle between the warp scheduler, the barrier controller and the cluster barrier.
interface vx_barrier_ctl_if #(
    parameter int unsigned NUM_WARPS    = 8,
    parameter int unsigned NUM_BARRIERS = 4,
    parameter int unsigned NW_WIDTH     = $clog2(NUM_WARPS)
);
    localparam int unsigned NB_WIDTH = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1;

    logic                 wctl_valid;
    logic [NW_WIDTH-1:0]  wctl_wid;
    logic                 bar_valid;
    logic [NB_WIDTH-1:0]  bar_id;
    logic                 bar_is_global;
    logic [NW_WIDTH-1:0]  bar_size_m1;
    logic [NUM_WARPS-1:0] active_warps;

    logic                 gbar_req_valid;
    logic                 gbar_req_ready;
    logic [NB_WIDTH-1:0]  gbar_req_id;
    logic [NW_WIDTH-1:0]  gbar_req_size_m1;
    logic                 gbar_rsp_valid;
    logic [NB_WIDTH-1:0]  gbar_rsp_id;

    logic                 unlock_valid;
    logic [NUM_WARPS-1:0] unlock_mask;
    logic [NUM_WARPS-1:0] barrier_stalls;

    // Scheduler/cluster side.
    modport master (
        output wctl_valid, wctl_wid, bar_valid, bar_id, bar_is_global, bar_size_m1,
        output active_warps, gbar_req_ready, gbar_rsp_valid, gbar_rsp_id,
        input  gbar_req_valid, gbar_req_id, gbar_req_size_m1,
        input  unlock_valid, unlock_mask, barrier_stalls
    );

    // Barrier controller side.
    modport slave (
        input  wctl_valid, wctl_wid, bar_valid, bar_id, bar_is_global, bar_size_m1,
        input  active_warps, gbar_req_ready, gbar_rsp_valid, gbar_rsp_id,
        output gbar_req_valid, gbar_req_id, gbar_req_size_m1,
        output unlock_valid, unlock_mask, barrier_stalls
    );
endinterface

// File: rtl/vx_barrier_ctl.sv
// Warp barrier controller: holds warps at local/global barriers and releases them.
module vx_barrier_ctl #(
    parameter int unsigned NUM_WARPS    = 8,
    parameter int unsigned NUM_BARRIERS = 4,
    parameter int unsigned NW_WIDTH     = $clog2(NUM_WARPS)
) (
    input logic             clk,
    input logic             reset,
    vx_barrier_ctl_if.slave bus
);
    localparam int unsigned NB_WIDTH = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1;

    logic [NUM_WARPS-1:0]    lmask_q [NUM_BARRIERS];
    logic [NUM_WARPS-1:0]    lmask_d [NUM_BARRIERS];
    logic [NW_WIDTH-1:0]     count_q [NUM_BARRIERS];
    logic [NW_WIDTH-1:0]     count_d [NUM_BARRIERS];
    logic [NUM_WARPS-1:0]    gmask_q [NUM_BARRIERS];
    logic [NUM_WARPS-1:0]    gmask_d [NUM_BARRIERS];
    logic [NW_WIDTH-1:0]     gsize_q [NUM_BARRIERS];
    logic [NW_WIDTH-1:0]     gsize_d [NUM_BARRIERS];
    logic [NUM_BARRIERS-1:0] req_pend_q, req_pend_d;
    logic [NUM_BARRIERS-1:0] wait_q, wait_d;

    logic                    req_valid_q, req_valid_d;
    logic [NB_WIDTH-1:0]     req_id_q, req_id_d;
    logic [NW_WIDTH-1:0]     req_size_q, req_size_d;
    logic                    unlock_valid_q, unlock_valid_d;
    logic [NUM_WARPS-1:0]    unlock_mask_q, unlock_mask_d;
    logic [NUM_WARPS-1:0]    stalls_q, stalls_d;

    logic                    arrive;
    logic [NB_WIDTH-1:0]     bid;
    logic [NB_WIDTH-1:0]     rid;
    logic [NUM_WARPS-1:0]    wid_oh;
    logic                    handshake;

    assign arrive    = bus.wctl_valid && bus.bar_valid;
    assign bid       = bus.bar_id;
    assign rid       = bus.gbar_rsp_id;
    assign wid_oh    = NUM_WARPS'(1) << bus.wctl_wid;
    assign handshake = req_valid_q && bus.gbar_req_ready;

    // Next-state for barrier tables, request arbiter and release/stall outputs.
    always_comb begin
        lmask_d        = lmask_q;
        count_d        = count_q;
        gmask_d        = gmask_q;
        gsize_d        = gsize_q;
        req_pend_d     = req_pend_q;
        wait_d         = wait_q;
        req_valid_d    = req_valid_q;
        req_id_d       = req_id_q;
        req_size_d     = req_size_q;
        unlock_mask_d  = '0;
        unlock_valid_d = 1'b0;
        stalls_d       = '0;

        // Cluster release of a barrier we are waiting on.
        if (bus.gbar_rsp_valid && wait_q[rid]) begin
            unlock_mask_d = unlock_mask_d | gmask_q[rid];
            gmask_d[rid]  = '0;
            wait_d[rid]   = 1'b0;
        end

        // Local arrival: release on the last expected warp, otherwise record it.
        if (arrive && !bus.bar_is_global && ((lmask_q[bid] & wid_oh) == '0)) begin
            if (count_q[bid] == bus.bar_size_m1) begin
                unlock_mask_d = unlock_mask_d | lmask_q[bid] | wid_oh;
                lmask_d[bid]  = '0;
                count_d[bid]  = '0;
            end else begin
                lmask_d[bid]  = lmask_q[bid] | wid_oh;
                count_d[bid]  = count_q[bid] + NW_WIDTH'(1);
            end
        end

        // Global arrival: record it and raise a request once all active warps are in.
        if (arrive && bus.bar_is_global && ((gmask_q[bid] & wid_oh) == '0)) begin
            gmask_d[bid] = gmask_d[bid] | wid_oh;
            if ((((gmask_q[bid] | wid_oh) & bus.active_warps) == bus.active_warps)
                && !req_pend_q[bid] && !wait_q[bid]) begin
                req_pend_d[bid] = 1'b1;
                gsize_d[bid]    = bus.bar_size_m1;
            end
        end

        // Accepted request moves to waiting for the cluster response.
        if (handshake) begin
            req_pend_d[req_id_q] = 1'b0;
            wait_d[req_id_q]     = 1'b1;
        end

        // Present the lowest pending id; hold the current one until accepted.
        if (!req_valid_q || handshake) begin
            req_valid_d = 1'b0;
            req_id_d    = '0;
            req_size_d  = '0;
            for (int i = int'(NUM_BARRIERS) - 1; i >= 0; i--) begin
                if (req_pend_d[i]) begin
                    req_valid_d = 1'b1;
                    req_id_d    = NB_WIDTH'(i);
                    req_size_d  = gsize_d[i];
                end
            end
        end

        unlock_valid_d = (unlock_mask_d != '0);
        for (int i = 0; i < int'(NUM_BARRIERS); i++) begin
            stalls_d = stalls_d | lmask_d[i] | gmask_d[i];
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(NUM_BARRIERS); i++) begin
                lmask_q[i] <= '0;
                count_q[i] <= '0;
                gmask_q[i] <= '0;
                gsize_q[i] <= '0;
            end
            req_pend_q     <= '0;
            wait_q         <= '0;
            req_valid_q    <= 1'b0;
            req_id_q       <= '0;
            req_size_q     <= '0;
            unlock_valid_q <= 1'b0;
            unlock_mask_q  <= '0;
            stalls_q       <= '0;
        end else begin
            lmask_q        <= lmask_d;
            count_q        <= count_d;
            gmask_q        <= gmask_d;
            gsize_q        <= gsize_d;
            req_pend_q     <= req_pend_d;
            wait_q         <= wait_d;
            req_valid_q    <= req_valid_d;
            req_id_q       <= req_id_d;
            req_size_q     <= req_size_d;
            unlock_valid_q <= unlock_valid_d;
            unlock_mask_q  <= unlock_mask_d;
            stalls_q       <= stalls_d;
        end
    end

    assign bus.gbar_req_valid   = req_valid_q;
    assign bus.gbar_req_id      = req_id_q;
    assign bus.gbar_req_size_m1 = req_size_q;
    assign bus.unlock_valid     = unlock_valid_q;
    assign bus.unlock_mask      = unlock_mask_q;
    assign bus.barrier_stalls   = stalls_q;
endmodule

// File: tb/tb_vx_barrier_ctl.sv
// Bench for vx_barrier_ctl: directed scenarios plus randomized traffic against a reference model.
module tb_vx_barrier_ctl;
    localparam int unsigned NW  = 8;
    localparam int unsigned NB  = 4;
    localparam int unsigned NWW = 3;
    localparam int unsigned NBW = 2;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_total = 0;
    int   n_pass  = 0;

    always #5 clk = ~clk;

    vx_barrier_ctl_if #(.NUM_WARPS(NW), .NUM_BARRIERS(NB), .NW_WIDTH(NWW)) bus ();

    vx_barrier_ctl #(.NUM_WARPS(NW), .NUM_BARRIERS(NB), .NW_WIDTH(NWW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Reference model state: which warps sit at which barrier, and request bookkeeping.
    logic [NW-1:0]  m_lmask [NB];
    logic [NW-1:0]  m_gmask [NB];
    logic [NWW-1:0] m_gsize [NB];
    logic [NB-1:0]  m_rpend, m_wait;
    logic           m_req_valid;
    logic [NBW-1:0] m_req_id;
    logic [NWW-1:0] m_req_size;
    logic           m_uv;
    logic [NW-1:0]  m_um, m_st;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, got, exp, $time);
    endtask

    // Literal expectation applied to both the DUT and the model.
    task automatic lit(input string name, input logic [31:0] dut_v, input logic [31:0] mdl_v,
                       input logic [31:0] exp);
        chk({name, "_dut"}, dut_v, exp);
        chk({name, "_model"}, mdl_v, exp);
    endtask

    // Model update: a warp count is the number of warps already waiting at that barrier.
    always @(posedge clk or negedge reset) begin : ref_model
        logic [NW-1:0]  lm [NB];
        logic [NW-1:0]  gm [NB];
        logic [NWW-1:0] gs [NB];
        logic [NB-1:0]  rp, wt;
        logic [NW-1:0]  oh, rel, st;
        logic           rv;
        logic [NBW-1:0] rqid;
        logic [NWW-1:0] rsz;
        int             e, r;
        if (!reset) begin
            m_lmask <= '{default: '0};
            m_gmask <= '{default: '0};
            m_gsize <= '{default: '0};
            m_rpend <= '0;
            m_wait <= '0;
            m_req_valid <= 1'b0;
            m_req_id <= '0;
            m_req_size <= '0;
            m_uv <= 1'b0;
            m_um <= '0;
            m_st <= '0;
        end else begin
            lm = m_lmask; gm = m_gmask; gs = m_gsize; rp = m_rpend; wt = m_wait;
            rel = '0;
            oh = NW'(1) << bus.wctl_wid;
            e = int'(bus.bar_id);
            r = int'(bus.gbar_rsp_id);
            if (bus.gbar_rsp_valid && m_wait[r]) begin
                rel = rel | m_gmask[r];
                gm[r] = '0;
                wt[r] = 1'b0;
            end
            if (bus.wctl_valid && bus.bar_valid) begin
                if (!bus.bar_is_global) begin
                    if ((m_lmask[e] & oh) == '0) begin
                        if ($countones(m_lmask[e]) == int'(bus.bar_size_m1)) begin
                            rel = rel | m_lmask[e] | oh;
                            lm[e] = '0;
                        end else begin
                            lm[e] = m_lmask[e] | oh;
                        end
                    end
                end else if ((m_gmask[e] & oh) == '0) begin
                    gm[e] = gm[e] | oh;
                    if ((((m_gmask[e] | oh) & bus.active_warps) == bus.active_warps)
                        && !m_rpend[e] && !m_wait[e]) begin
                        rp[e] = 1'b1;
                        gs[e] = bus.bar_size_m1;
                    end
                end
            end
            rv = m_req_valid; rqid = m_req_id; rsz = m_req_size;
            if (m_req_valid && bus.gbar_req_ready) begin
                rp[m_req_id] = 1'b0;
                wt[m_req_id] = 1'b1;
                rv = 1'b0;
            end
            if (!rv) begin
                rqid = '0; rsz = '0;
                for (int i = 0; i < int'(NB); i++) begin
                    if (rp[i] && !rv) begin
                        rv = 1'b1; rqid = NBW'(i); rsz = gs[i];
                    end
                end
            end
            st = '0;
            for (int i = 0; i < int'(NB); i++) st = st | lm[i] | gm[i];
            m_lmask <= lm; m_gmask <= gm; m_gsize <= gs; m_rpend <= rp; m_wait <= wt;
            m_req_valid <= rv; m_req_id <= rqid; m_req_size <= rsz;
            m_uv <= (rel != '0); m_um <= rel; m_st <= st;
        end
    end

    // Per-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        if (reset) begin
            chk("unlock_valid", 32'(bus.unlock_valid), 32'(m_uv));
            chk("unlock_mask", 32'(bus.unlock_mask), 32'(m_um));
            chk("barrier_stalls", 32'(bus.barrier_stalls), 32'(m_st));
            chk("gbar_req_valid", 32'(bus.gbar_req_valid), 32'(m_req_valid));
            if (m_req_valid) begin
                chk("gbar_req_id", 32'(bus.gbar_req_id), 32'(m_req_id));
                chk("gbar_req_size_m1", 32'(bus.gbar_req_size_m1), 32'(m_req_size));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        bus.wctl_valid = 1'b0; bus.wctl_wid = '0; bus.bar_valid = 1'b0; bus.bar_id = '0;
        bus.bar_is_global = 1'b0; bus.bar_size_m1 = '0; bus.gbar_req_ready = 1'b0;
        bus.gbar_rsp_valid = 1'b0; bus.gbar_rsp_id = '0;
    endtask

    task automatic arr(input int w, input int id, input bit g, input int sz);
        bus.wctl_valid = 1'b1; bus.bar_valid = 1'b1; bus.wctl_wid = NWW'(w);
        bus.bar_id = NBW'(id); bus.bar_is_global = g; bus.bar_size_m1 = NWW'(sz);
    endtask

    task automatic rsp(input int id);
        bus.gbar_rsp_valid = 1'b1; bus.gbar_rsp_id = NBW'(id);
    endtask

    initial begin
        logic [NW-1:0] act;
        int            w;
        idle();
        bus.active_warps = '0;
        cyc(); cyc();
        lit("rst_unlock_valid", 32'(bus.unlock_valid), 32'(m_uv), 0);
        lit("rst_stalls", 32'(bus.barrier_stalls), 32'(m_st), 0);
        lit("rst_req_valid", 32'(bus.gbar_req_valid), 32'(m_req_valid), 0);
        reset = 1'b1;
        cyc();

        // Local barrier of four warps.
        arr(0, 1, 0, 3); cyc(); lit("loc4_st1", 32'(bus.barrier_stalls), 32'(m_st), 32'h1);
        arr(1, 1, 0, 3); cyc(); lit("loc4_st2", 32'(bus.barrier_stalls), 32'(m_st), 32'h3);
        arr(2, 1, 0, 3); cyc(); lit("loc4_st3", 32'(bus.barrier_stalls), 32'(m_st), 32'h7);
        lit("loc4_nouv", 32'(bus.unlock_valid), 32'(m_uv), 0);
        arr(3, 1, 0, 3); cyc();
        lit("loc4_uv", 32'(bus.unlock_valid), 32'(m_uv), 1);
        lit("loc4_mask", 32'(bus.unlock_mask), 32'(m_um), 32'hF);
        lit("loc4_st4", 32'(bus.barrier_stalls), 32'(m_st), 0);
        idle(); cyc(); lit("loc4_pulse", 32'(bus.unlock_valid), 32'(m_uv), 0);

        // Single-warp barrier releases at once.
        arr(5, 0, 0, 0); cyc();
        lit("sz1_uv", 32'(bus.unlock_valid), 32'(m_uv), 1);
        lit("sz1_mask", 32'(bus.unlock_mask), 32'(m_um), 32'h20);
        lit("sz1_st", 32'(bus.barrier_stalls), 32'(m_st), 0);
        idle(); cyc(); lit("sz1_pulse", 32'(bus.unlock_valid), 32'(m_uv), 0);

        // Global barrier with backpressure.
        bus.active_warps = 8'h03;
        arr(0, 2, 1, 0); cyc();
        lit("glb_st1", 32'(bus.barrier_stalls), 32'(m_st), 32'h1);
        lit("glb_noreq", 32'(bus.gbar_req_valid), 32'(m_req_valid), 0);
        arr(1, 2, 1, 5); cyc();
        lit("glb_req", 32'(bus.gbar_req_valid), 32'(m_req_valid), 1);
        lit("glb_id", 32'(bus.gbar_req_id), 32'(m_req_id), 2);
        lit("glb_size", 32'(bus.gbar_req_size_m1), 32'(m_req_size), 5);
        idle();
        for (int i = 0; i < 3; i++) begin
            cyc();
            lit("glb_hold", 32'(bus.gbar_req_valid), 32'(m_req_valid), 1);
            lit("glb_hold_id", 32'(bus.gbar_req_id), 32'(m_req_id), 2);
        end
        bus.gbar_req_ready = 1'b1; cyc();
        lit("glb_acc", 32'(bus.gbar_req_valid), 32'(m_req_valid), 0);
        lit("glb_st2", 32'(bus.barrier_stalls), 32'(m_st), 32'h3);
        idle(); rsp(2); cyc();
        lit("glb_uv", 32'(bus.unlock_valid), 32'(m_uv), 1);
        lit("glb_mask", 32'(bus.unlock_mask), 32'(m_um), 32'h3);
        lit("glb_st3", 32'(bus.barrier_stalls), 32'(m_st), 0);
        idle(); cyc();

        // Local release and global response merged into one pulse.
        bus.active_warps = 8'h0A;
        arr(1, 3, 1, 0); cyc();
        arr(3, 3, 1, 0); cyc();
        lit("mrg_req_id", 32'(bus.gbar_req_id), 32'(m_req_id), 3);
        idle(); bus.gbar_req_ready = 1'b1; cyc();
        idle(); arr(0, 0, 0, 1); cyc();
        lit("mrg_st", 32'(bus.barrier_stalls), 32'(m_st), 32'hB);
        arr(2, 0, 0, 1); rsp(3); cyc();
        lit("mrg_uv", 32'(bus.unlock_valid), 32'(m_uv), 1);
        lit("mrg_mask", 32'(bus.unlock_mask), 32'(m_um), 32'hF);
        lit("mrg_st2", 32'(bus.barrier_stalls), 32'(m_st), 0);
        idle(); cyc(); lit("mrg_pulse", 32'(bus.unlock_valid), 32'(m_uv), 0);

        // Duplicate arrival is ignored.
        arr(2, 1, 0, 1); cyc();
        arr(2, 1, 0, 1); cyc();
        lit("dup_uv", 32'(bus.unlock_valid), 32'(m_uv), 0);
        lit("dup_st", 32'(bus.barrier_stalls), 32'(m_st), 32'h4);
        arr(4, 1, 0, 1); cyc();
        lit("dup_mask", 32'(bus.unlock_mask), 32'(m_um), 32'h14);
        lit("dup_st2", 32'(bus.barrier_stalls), 32'(m_st), 0);
        idle(); cyc();

        // Reset in the middle of local and global barriers.
        arr(1, 1, 0, 3); cyc();
        bus.active_warps = 8'h04;
        arr(2, 2, 1, 0); cyc(); idle();
        lit("mid_st", 32'(bus.barrier_stalls), 32'(m_st), 32'h6);
        lit("mid_req", 32'(bus.gbar_req_valid), 32'(m_req_valid), 1);
        #1 reset = 1'b0;
        #1;
        lit("mid_rst_st", 32'(bus.barrier_stalls), 32'(m_st), 0);
        lit("mid_rst_req", 32'(bus.gbar_req_valid), 32'(m_req_valid), 0);
        lit("mid_rst_uv", 32'(bus.unlock_valid), 32'(m_uv), 0);
        cyc(); reset = 1'b1;
        rsp(2); cyc();
        lit("stray_uv", 32'(bus.unlock_valid), 32'(m_uv), 0);
        lit("stray_st", 32'(bus.barrier_stalls), 32'(m_st), 0);
        idle(); cyc();

        // Randomized epochs, each starting from reset.
        for (int ep = 0; ep < 6; ep++) begin
            reset = 1'b0; idle(); cyc(); cyc(); reset = 1'b1;
            act = NW'($urandom);
            if (act == '0) act = NW'(1);
            bus.active_warps = act;
            for (int c = 0; c < 400; c++) begin
                idle();
                w = int'($urandom_range(NW - 1));
                if ($urandom_range(1) == 1 && (!m_st[w] || $urandom_range(7) == 0)) begin
                    arr(w, int'($urandom_range(NB - 1)), ($urandom_range(2) == 0),
                        int'($urandom_range(3)));
                    if ($urandom_range(7) == 0) bus.bar_valid = 1'b0;
                end else begin
                    bus.bar_valid = 1'($urandom_range(1));
                    bus.bar_id = NBW'($urandom);
                    bus.wctl_wid = NWW'($urandom);
                end
                bus.gbar_req_ready = 1'($urandom_range(1));
                if ($urandom_range(2) == 0) rsp(int'($urandom_range(NB - 1)));
                cyc();
            end
        end

        idle(); cyc(); cyc();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
